branch_resolve_unit: RTL and testbench

- Sits directly downstream of the branch hazard detector. It consumes that stage's branch-detect strobe (MPC), the forwarded V/C/N/Z/L flags, opcode and PC, and resolves conditional branches.
- Static not-taken prediction: a taken branch is a misprediction. The block drives a held PC redirect to fetch (valid/ready handshake), flushes wrong-path pipeline stages for a programmable number of cycles, and keeps saturating branch statistics.

---
 rtl/branch_resolve_if.sv | 39 +++
 rtl/branch_resolve_unit.sv | 127 ++++++++++++
 tb/tb_branch_resolve_unit.sv | 375 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_if.sv
// Hazard-stage -> branch resolve -> fetch signal bundle, one instance per resolve unit.
// Latency: none (wires only).
// Backpressure: redirect_valid/redirect_ready handshake toward fetch; branch side has no ready.
//
// master: the surrounding pipeline (hazard stage and fetch); slave: branch_resolve_unit.
interface branch_resolve_if #(
    parameter int CNT_W = 16
);
    logic             br_valid;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic             flag_v;
    logic             flag_c;
    logic             flag_n;
    logic             flag_z;
    logic             flag_l;
    logic [31:0]      pc_branch;
    logic [31:0]      imm_b;
    logic             redirect_ready;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic             flush;
    logic             busy;
    logic             illegal_br;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] taken_cnt;

    modport master (
        output br_valid, opcode, funct3, flag_v, flag_c, flag_n, flag_z, flag_l,
               pc_branch, imm_b, redirect_ready,
        input  redirect_valid, redirect_pc, flush, busy, illegal_br, branch_cnt, taken_cnt
    );

    modport slave (
        input  br_valid, opcode, funct3, flag_v, flag_c, flag_n, flag_z, flag_l,
               pc_branch, imm_b, redirect_ready,
        output redirect_valid, redirect_pc, flush, busy, illegal_br, branch_cnt, taken_cnt
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Resolves conditional branches under static not-taken prediction; redirects fetch and flushes on taken.
// Latency: redirect_valid/flush assert 1 cycle after acceptance; flush lasts FLUSH_CYCLES after handshake.
// Backpressure: redirect held stable until redirect_ready; branches arriving while busy are dropped.
//
// Ports: clk, rst (sync, active-high); bus (slave modport) carries the branch strobe, flags,
// opcode/funct3, pc/imm, the fetch redirect handshake, flush/busy/illegal_br and statistics.
module branch_resolve_unit #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic               clk,
    input  logic               rst,
    branch_resolve_if.slave    bus
);

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    state_t           state;
    logic [3:0]       flush_cnt;
    logic             redirect_valid_q;
    logic [31:0]      redirect_pc_q;
    logic             flush_q;
    logic             busy_q;
    logic             illegal_q;
    logic [CNT_W-1:0] branch_cnt_q;
    logic [CNT_W-1:0] taken_cnt_q;

    logic             accept;
    logic             taken;
    logic             illegal;
    logic [31:0]      target_sum;
    logic [31:0]      target;

    // Carry flag is forwarded but no supported condition needs it.
    logic unused_flag_c;
    assign unused_flag_c = bus.flag_c;

    assign accept     = bus.br_valid && (bus.opcode == OPC_BRANCH) && (state == IDLE);
    assign target_sum = bus.pc_branch + bus.imm_b;
    assign target     = {target_sum[31:1], 1'b0};

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (bus.funct3)
            3'b000:  taken = bus.flag_z;
            3'b001:  taken = !bus.flag_z;
            3'b100:  taken = bus.flag_n ^ bus.flag_v;
            3'b101:  taken = !(bus.flag_n ^ bus.flag_v);
            3'b110:  taken = bus.flag_l;
            3'b111:  taken = !bus.flag_l;
            default: illegal = 1'b1;   // 010/011 reserved: resolved as not taken
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            flush_cnt        <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            flush_q          <= 1'b0;
            busy_q           <= 1'b0;
            illegal_q        <= 1'b0;
            branch_cnt_q     <= '0;
            taken_cnt_q      <= '0;
        end else begin
            illegal_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        redirect_pc_q <= target;
                        illegal_q     <= illegal;
                        if (branch_cnt_q != '1)
                            branch_cnt_q <= branch_cnt_q + CNT_W'(1);
                        if (taken) begin
                            if (taken_cnt_q != '1)
                                taken_cnt_q <= taken_cnt_q + CNT_W'(1);
                            state            <= REDIRECT;
                            redirect_valid_q <= 1'b1;
                            flush_q          <= 1'b1;
                            busy_q           <= 1'b1;
                        end
                    end
                end
                REDIRECT: begin
                    if (bus.redirect_ready) begin
                        state            <= FLUSH;
                        redirect_valid_q <= 1'b0;
                        flush_cnt        <= 4'(FLUSH_CYCLES);
                    end
                end
                FLUSH: begin
                    // Count loaded at handshake, so the FLUSH state spans exactly FLUSH_CYCLES cycles.
                    if (flush_cnt <= 4'd1) begin
                        state   <= IDLE;
                        flush_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt - 4'd1;
                    end
                end
                default: begin
                    state            <= IDLE;
                    redirect_valid_q <= 1'b0;
                    flush_q          <= 1'b0;
                    busy_q           <= 1'b0;
                end
            endcase
        end
    end

    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.flush          = flush_q;
    assign bus.busy           = busy_q;
    assign bus.illegal_br     = illegal_q;
    assign bus.branch_cnt     = branch_cnt_q;
    assign bus.taken_cnt      = taken_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

    localparam logic [6:0] OPC_BR  = 7'b1100011;
    localparam logic [6:0] OPC_ALU = 7'b0110011;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    branch_resolve_if #(.CNT_W(16)) bi ();
    branch_resolve_if #(.CNT_W(2))  bs ();

    branch_resolve_unit #(.FLUSH_CYCLES(2), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bi)
    );

    branch_resolve_unit #(.FLUSH_CYCLES(2), .CNT_W(2)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bs)
    );

    // Saturation instance sees the same stimulus as the main one.
    assign bs.br_valid       = bi.br_valid;
    assign bs.opcode         = bi.opcode;
    assign bs.funct3         = bi.funct3;
    assign bs.flag_v         = bi.flag_v;
    assign bs.flag_c         = bi.flag_c;
    assign bs.flag_n         = bi.flag_n;
    assign bs.flag_z         = bi.flag_z;
    assign bs.flag_l         = bi.flag_l;
    assign bs.pc_branch      = bi.pc_branch;
    assign bs.imm_b          = bi.imm_b;
    assign bs.redirect_ready = bi.redirect_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_br(input logic [6:0] opc, input logic [2:0] f3,
                          input logic n, input logic v, input logic z, input logic l,
                          input logic [31:0] pc, input logic [31:0] imm);
        bi.br_valid  = 1'b1;
        bi.opcode    = opc;
        bi.funct3    = f3;
        bi.flag_n    = n;
        bi.flag_v    = v;
        bi.flag_z    = z;
        bi.flag_l    = l;
        bi.flag_c    = 1'b0;
        bi.pc_branch = pc;
        bi.imm_b     = imm;
    endtask

    task automatic do_reset();
        bi.br_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bi.redirect_ready = 1'b1;
        do_reset();
        checks++;
        if ({bi.redirect_valid, bi.flush, bi.busy, bi.illegal_br} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got=%b want=0000",
                     {bi.redirect_valid, bi.flush, bi.busy, bi.illegal_br});
        end
        checks++;
        if (bi.redirect_pc !== 32'h0 || bi.branch_cnt !== 16'd0 || bi.taken_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_values pc=%h bc=%0d tc=%0d want 0/0/0",
                     bi.redirect_pc, bi.branch_cnt, bi.taken_cnt);
        end
    endtask

    task automatic test_beq_taken();
        int nflush;
        do_reset();
        bi.redirect_ready = 1'b1;
        set_br(OPC_BR, 3'b000, 0, 0, 1, 0, 32'h100, 32'h20);
        step();
        bi.br_valid = 1'b0;
        checks++;
        if (bi.redirect_valid !== 1'b1 || bi.redirect_pc !== 32'h120 || bi.busy !== 1'b1) begin
            errors++;
            $display("FAIL beq_redirect valid=%b pc=%h busy=%b want 1/120/1",
                     bi.redirect_valid, bi.redirect_pc, bi.busy);
        end
        checks++;
        if (bi.branch_cnt !== 16'd1 || bi.taken_cnt !== 16'd1) begin
            errors++;
            $display("FAIL beq_counts bc=%0d tc=%0d want 1/1", bi.branch_cnt, bi.taken_cnt);
        end
        nflush = 0;
        for (int i = 0; i < 6; i++) begin
            if (bi.flush === 1'b1) nflush++;
            step();
        end
        checks++;
        if (nflush != 3) begin
            errors++;
            $display("FAIL beq_flush_len got=%0d want=3", nflush);
        end
        checks++;
        if (bi.busy !== 1'b0 || bi.flush !== 1'b0) begin
            errors++;
            $display("FAIL beq_idle busy=%b flush=%b want 0/0", bi.busy, bi.flush);
        end
    endtask

    task automatic test_bne_not_taken();
        do_reset();
        set_br(OPC_BR, 3'b001, 0, 0, 1, 0, 32'h200, 32'h40);
        step();
        bi.br_valid = 1'b0;
        checks++;
        if ({bi.redirect_valid, bi.flush, bi.busy} !== 3'b000) begin
            errors++;
            $display("FAIL bne_no_redirect got=%b want=000",
                     {bi.redirect_valid, bi.flush, bi.busy});
        end
        checks++;
        if (bi.branch_cnt !== 16'd1 || bi.taken_cnt !== 16'd0) begin
            errors++;
            $display("FAIL bne_counts bc=%0d tc=%0d want 1/0", bi.branch_cnt, bi.taken_cnt);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        bi.redirect_ready = 1'b0;
        set_br(OPC_BR, 3'b100, 1, 0, 0, 0, 32'h2000, 32'hFFFF_FFF0);
        step();
        bi.br_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bi.redirect_valid !== 1'b1 || bi.redirect_pc !== 32'h1FF0 || bi.flush !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold cyc=%0d valid=%b pc=%h flush=%b want 1/1ff0/1",
                         i, bi.redirect_valid, bi.redirect_pc, bi.flush);
            end
            step();
        end
        bi.redirect_ready = 1'b1;
        step();
        checks++;
        if (bi.redirect_valid !== 1'b0 || bi.flush !== 1'b1 || bi.busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_flush_start valid=%b flush=%b busy=%b want 0/1/1",
                     bi.redirect_valid, bi.flush, bi.busy);
        end
        step();
        step();
        checks++;
        if (bi.busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_return_idle busy=%b want 0", bi.busy);
        end
    endtask

    task automatic test_wrong_path();
        do_reset();
        bi.redirect_ready = 1'b0;
        set_br(OPC_BR, 3'b000, 0, 0, 1, 0, 32'h300, 32'h40);
        step();
        bi.pc_branch = 32'h500;
        step();
        step();
        checks++;
        if (bi.redirect_pc !== 32'h340 || bi.branch_cnt !== 16'd1 || bi.taken_cnt !== 16'd1) begin
            errors++;
            $display("FAIL wp_redirect pc=%h bc=%0d tc=%0d want 340/1/1",
                     bi.redirect_pc, bi.branch_cnt, bi.taken_cnt);
        end
        bi.redirect_ready = 1'b1;
        step();
        step();
        checks++;
        if (bi.redirect_pc !== 32'h340 || bi.branch_cnt !== 16'd1 || bi.taken_cnt !== 16'd1
            || bi.flush !== 1'b1) begin
            errors++;
            $display("FAIL wp_flush pc=%h bc=%0d tc=%0d flush=%b want 340/1/1/1",
                     bi.redirect_pc, bi.branch_cnt, bi.taken_cnt, bi.flush);
        end
        bi.br_valid = 1'b0;
        step();
        checks++;
        if (bi.busy !== 1'b0) begin
            errors++;
            $display("FAIL wp_idle busy=%b want 0", bi.busy);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        bi.redirect_ready = 1'b1;
        set_br(OPC_BR, 3'b111, 0, 0, 0, 0, 32'hFFFF_FFF0, 32'h0000_0014);
        step();
        bi.br_valid = 1'b0;
        checks++;
        if (bi.redirect_valid !== 1'b1 || bi.redirect_pc !== 32'h4) begin
            errors++;
            $display("FAIL wrap_target valid=%b pc=%h want 1/00000004",
                     bi.redirect_valid, bi.redirect_pc);
        end
        repeat (3) step();
        set_br(OPC_BR, 3'b000, 0, 0, 1, 0, 32'h100, 32'h21);
        step();
        bi.br_valid = 1'b0;
        checks++;
        if (bi.redirect_valid !== 1'b1 || bi.redirect_pc !== 32'h120) begin
            errors++;
            $display("FAIL odd_target valid=%b pc=%h want 1/00000120",
                     bi.redirect_valid, bi.redirect_pc);
        end
        repeat (3) step();
    endtask

    task automatic test_illegal();
        do_reset();
        set_br(OPC_BR, 3'b010, 1, 0, 1, 1, 32'h400, 32'h8);
        step();
        bi.br_valid = 1'b0;
        checks++;
        if (bi.illegal_br !== 1'b1 || bi.redirect_valid !== 1'b0 || bi.busy !== 1'b0) begin
            errors++;
            $display("FAIL illegal_pulse ill=%b valid=%b busy=%b want 1/0/0",
                     bi.illegal_br, bi.redirect_valid, bi.busy);
        end
        checks++;
        if (bi.branch_cnt !== 16'd1 || bi.taken_cnt !== 16'd0) begin
            errors++;
            $display("FAIL illegal_counts bc=%0d tc=%0d want 1/0", bi.branch_cnt, bi.taken_cnt);
        end
        step();
        checks++;
        if (bi.illegal_br !== 1'b0) begin
            errors++;
            $display("FAIL illegal_one_cycle ill=%b want 0", bi.illegal_br);
        end
        set_br(OPC_ALU, 3'b000, 0, 0, 1, 0, 32'h500, 32'h8);
        step();
        bi.br_valid = 1'b0;
        checks++;
        if (bi.branch_cnt !== 16'd1 || bi.redirect_valid !== 1'b0 || bi.illegal_br !== 1'b0) begin
            errors++;
            $display("FAIL non_branch_opcode bc=%0d valid=%b ill=%b want 1/0/0",
                     bi.branch_cnt, bi.redirect_valid, bi.illegal_br);
        end
    endtask

    task automatic test_conditions();
        // {funct3, n, v, z, l, expected_taken}
        logic [7:0] vec [8];
        logic [7:0] e;
        vec[0] = {3'b000, 4'b0000, 1'b0};
        vec[1] = {3'b001, 4'b0000, 1'b1};
        vec[2] = {3'b100, 4'b1100, 1'b0};
        vec[3] = {3'b100, 4'b0100, 1'b1};
        vec[4] = {3'b101, 4'b1000, 1'b0};
        vec[5] = {3'b101, 4'b0000, 1'b1};
        vec[6] = {3'b110, 4'b0001, 1'b1};
        vec[7] = {3'b111, 4'b0001, 1'b0};
        do_reset();
        bi.redirect_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            e = vec[i];
            set_br(OPC_BR, e[7:5], e[4], e[3], e[2], e[1], 32'h1000, 32'h10);
            step();
            bi.br_valid = 1'b0;
            checks++;
            if (bi.redirect_valid !== e[0]) begin
                errors++;
                $display("FAIL cond_%0d f3=%b got=%b want=%b", i, e[7:5], bi.redirect_valid, e[0]);
            end
            repeat (3) step();
        end
        checks++;
        if (bi.branch_cnt !== 16'd8 || bi.taken_cnt !== 16'd4) begin
            errors++;
            $display("FAIL cond_counts bc=%0d tc=%0d want 8/4", bi.branch_cnt, bi.taken_cnt);
        end
    endtask

    task automatic test_reset_mid_flush();
        do_reset();
        bi.redirect_ready = 1'b1;
        set_br(OPC_BR, 3'b000, 0, 0, 1, 0, 32'h600, 32'h30);
        step();
        bi.br_valid = 1'b0;
        step();
        checks++;
        if (bi.flush !== 1'b1 || bi.redirect_valid !== 1'b0) begin
            errors++;
            $display("FAIL midflush_pre flush=%b valid=%b want 1/0", bi.flush, bi.redirect_valid);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({bi.redirect_valid, bi.flush, bi.busy, bi.illegal_br} !== 4'b0000
            || bi.redirect_pc !== 32'h0 || bi.branch_cnt !== 16'd0 || bi.taken_cnt !== 16'd0) begin
            errors++;
            $display("FAIL midflush_reset flags=%b pc=%h bc=%0d tc=%0d want 0000/0/0/0",
                     {bi.redirect_valid, bi.flush, bi.busy, bi.illegal_br},
                     bi.redirect_pc, bi.branch_cnt, bi.taken_cnt);
        end
        step();
        checks++;
        if (bi.busy !== 1'b0 || bi.flush !== 1'b0) begin
            errors++;
            $display("FAIL midflush_stays_idle busy=%b flush=%b want 0/0", bi.busy, bi.flush);
        end
    endtask

    task automatic test_back_to_back_saturation();
        do_reset();
        bi.redirect_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_br(OPC_BR, 3'b000, 0, 0, 1, 0, 32'h700, 32'h10);
            step();
            bi.br_valid = 1'b0;
            repeat (3) step();
            checks++;
            if (bi.busy !== 1'b0) begin
                errors++;
                $display("FAIL b2b_idle_%0d busy=%b want 0", i, bi.busy);
            end
        end
        checks++;
        if (bs.taken_cnt !== 2'd3 || bs.branch_cnt !== 2'd3) begin
            errors++;
            $display("FAIL sat_cnt2 bc=%0d tc=%0d want 3/3", bs.branch_cnt, bs.taken_cnt);
        end
        checks++;
        if (bi.taken_cnt !== 16'd5 || bi.branch_cnt !== 16'd5) begin
            errors++;
            $display("FAIL sat_cnt16 bc=%0d tc=%0d want 5/5", bi.branch_cnt, bi.taken_cnt);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bi.br_valid = 1'b0;
        bi.redirect_ready = 1'b0;
        set_br(OPC_ALU, 3'b000, 0, 0, 0, 0, 32'h0, 32'h0);
        bi.br_valid = 1'b0;
        step();
        test_reset();
        test_beq_taken();
        test_bne_not_taken();
        test_backpressure();
        test_wrong_path();
        test_wrap();
        test_illegal();
        test_conditions();
        test_reset_mid_flush();
        test_back_to_back_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
